vtage_value_table_mp: RTL and testbench

Parametrised multi-port value table, the successor to the current two-read/two-write VTAGE value table.
- Generalised to P_NUM_RD read and P_NUM_WR write ports on a single clock, replacing the multipumped RAM clock.
- Adds a reset-time initialisation sweep, deterministic write-write conflict resolution, optional write-to-read bypass, and per-port read-valid tracking.
- Sits between VTAGE prediction lookup (read side) and commit-time training/update (write side).

---
 rtl/vtage_pkg.sv | 23 ++
 rtl/vtage_vt_wr_arbiter.sv | 29 ++
 rtl/vtage_value_table_mp.sv | 127 ++++++++++++
 tb/tb_vtage_value_table_mp.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/vtage_pkg.sv
// Shared types and default sizing for the VTAGE multi-port value table.
package vtage_pkg;

    localparam int VT_DEF_STORAGE_SIZE  = 2048;
    localparam int VT_DEF_DATA_WIDTH    = 32;
    localparam int VT_DEF_NUM_RD        = 2;
    localparam int VT_DEF_NUM_WR        = 2;
    localparam int VT_DEF_BYPASS        = 1;
    localparam int VT_DEF_ADDRESS_WIDTH = $clog2(VT_DEF_STORAGE_SIZE);

    typedef logic [VT_DEF_ADDRESS_WIDTH-1:0] vt_addr_t;
    typedef logic [VT_DEF_DATA_WIDTH-1:0]    vt_data_t;

    typedef enum logic {
        VT_INIT = 1'b0,
        VT_RUN  = 1'b1
    } vt_state_e;

    function automatic int vt_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/vtage_vt_wr_arbiter.sv
// Resolves same-cycle writes to one address: the highest-indexed valid port survives.
module vtage_vt_wr_arbiter
    import vtage_pkg::*;
#(
    parameter int P_NUM_WR        = VT_DEF_NUM_WR,
    parameter int P_ADDRESS_WIDTH = VT_DEF_ADDRESS_WIDTH
) (
    input  logic [P_NUM_WR*P_ADDRESS_WIDTH-1:0] wr_addr_i,
    input  logic [P_NUM_WR-1:0]                 wr_valid_i,
    output logic [P_NUM_WR-1:0]                 wr_keep_o,
    output logic                                wr_conflict_o
);

    always_comb begin
        wr_keep_o     = wr_valid_i;
        wr_conflict_o = 1'b0;
        for (int i = 0; i < P_NUM_WR; i++) begin
            for (int j = i + 1; j < P_NUM_WR; j++) begin
                if (wr_valid_i[i] && wr_valid_i[j] &&
                    (wr_addr_i[i*P_ADDRESS_WIDTH +: P_ADDRESS_WIDTH] ==
                     wr_addr_i[j*P_ADDRESS_WIDTH +: P_ADDRESS_WIDTH])) begin
                    wr_keep_o[i]  = 1'b0;
                    wr_conflict_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vtage_value_table_mp.sv
// Multi-port VTAGE value table: init sweep FSM, arbitrated writes, 1-cycle reads with optional bypass.
module vtage_value_table_mp
    import vtage_pkg::*;
#(
    parameter int                      P_STORAGE_SIZE = VT_DEF_STORAGE_SIZE,
    parameter int                      P_DATA_WIDTH   = VT_DEF_DATA_WIDTH,
    parameter int                      P_NUM_RD       = VT_DEF_NUM_RD,
    parameter int                      P_NUM_WR       = VT_DEF_NUM_WR,
    parameter logic [P_DATA_WIDTH-1:0] P_INIT_VALUE   = '0,
    parameter int                      P_BYPASS       = VT_DEF_BYPASS,
    localparam int                     LP_ADDRESS_WIDTH = $clog2(P_STORAGE_SIZE)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [P_NUM_RD*LP_ADDRESS_WIDTH-1:0] rd_addr_i,
    input  logic [P_NUM_RD-1:0]                  rd_valid_i,
    output logic [P_NUM_RD*P_DATA_WIDTH-1:0]     rd_data_o,
    output logic [P_NUM_RD-1:0]                  rd_valid_o,
    input  logic [P_NUM_WR*LP_ADDRESS_WIDTH-1:0] wr_addr_i,
    input  logic [P_NUM_WR*P_DATA_WIDTH-1:0]     wr_data_i,
    input  logic [P_NUM_WR-1:0]                  wr_valid_i,
    output logic                                 init_done_o,
    output logic                                 wr_conflict_o
);

    localparam int AW             = LP_ADDRESS_WIDTH;
    localparam int DW             = P_DATA_WIDTH;
    localparam int LP_INIT_CYCLES = P_STORAGE_SIZE / P_NUM_WR;
    localparam int LP_CNT_W       = vt_cnt_width(LP_INIT_CYCLES);
    localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(LP_INIT_CYCLES - 1);

    vt_state_e               state_q, state_d;
    logic [LP_CNT_W-1:0]     cnt_q, cnt_d;
    logic                    init_done_q;
    logic                    wr_conflict_q;
    logic [P_NUM_RD-1:0]     rd_valid_q, rd_valid_d;
    logic [P_NUM_RD*DW-1:0]  rd_data_q, rd_data_d;
    logic [DW-1:0]           mem_q [P_STORAGE_SIZE];

    logic                    run;
    logic [P_NUM_WR-1:0]     wr_valid_run;
    logic [P_NUM_WR-1:0]     wr_keep;
    logic                    wr_conflict;

    assign run          = (state_q == VT_RUN);
    assign wr_valid_run = wr_valid_i & {P_NUM_WR{run}};

    vtage_vt_wr_arbiter #(
        .P_NUM_WR        (P_NUM_WR),
        .P_ADDRESS_WIDTH (AW)
    ) u_wr_arbiter (
        .wr_addr_i     (wr_addr_i),
        .wr_valid_i    (wr_valid_run),
        .wr_keep_o     (wr_keep),
        .wr_conflict_o (wr_conflict)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == VT_INIT) begin
            if (cnt_q == LP_CNT_LAST) begin
                state_d = VT_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Read path: surviving writes forward to matching reads when bypass is enabled
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_i & {P_NUM_RD{run}};
        for (int k = 0; k < P_NUM_RD; k++) begin
            if (rd_valid_d[k]) begin
                rd_data_d[k*DW +: DW] = mem_q[rd_addr_i[k*AW +: AW]];
                if (P_BYPASS != 0) begin
                    for (int j = 0; j < P_NUM_WR; j++) begin
                        if (wr_keep[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW])) begin
                            rd_data_d[k*DW +: DW] = wr_data_i[j*DW +: DW];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= VT_INIT;
            cnt_q         <= '0;
            init_done_q   <= 1'b0;
            wr_conflict_q <= 1'b0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_done_q   <= run;
            wr_conflict_q <= wr_conflict;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Array has no reset; the sweep covers P_NUM_WR consecutive entries per cycle
    always_ff @(posedge clk_i) begin
        if (state_q == VT_INIT) begin
            for (int j = 0; j < P_NUM_WR; j++) begin
                mem_q[AW'(cnt_q) * AW'(P_NUM_WR) + AW'(j)] <= P_INIT_VALUE;
            end
        end else begin
            for (int j = 0; j < P_NUM_WR; j++) begin
                if (wr_keep[j]) begin
                    mem_q[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*DW +: DW];
                end
            end
        end
    end

    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign init_done_o   = init_done_q;
    assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_vtage_value_table_mp.sv
// Directed bench for vtage_value_table_mp: bypass and read-first instances share one stimulus stream.
module tb_vtage_value_table_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [1:0]  rd_valid;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_valid;

    logic [15:0] rd_data_b1, rd_data_b0;
    logic [1:0]  rd_valid_b1, rd_valid_b0;
    logic        init_b1, init_b0, conf_b1, conf_b0;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    vtage_value_table_mp #(
        .P_STORAGE_SIZE (16), .P_DATA_WIDTH (8), .P_NUM_RD (2), .P_NUM_WR (2),
        .P_INIT_VALUE   (8'hA5), .P_BYPASS (1)
    ) dut_b1 (
        .clk_i (clk), .rst_i (rst),
        .rd_addr_i (rd_addr), .rd_valid_i (rd_valid),
        .rd_data_o (rd_data_b1), .rd_valid_o (rd_valid_b1),
        .wr_addr_i (wr_addr), .wr_data_i (wr_data), .wr_valid_i (wr_valid),
        .init_done_o (init_b1), .wr_conflict_o (conf_b1)
    );

    vtage_value_table_mp #(
        .P_STORAGE_SIZE (16), .P_DATA_WIDTH (8), .P_NUM_RD (2), .P_NUM_WR (2),
        .P_INIT_VALUE   (8'hA5), .P_BYPASS (0)
    ) dut_b0 (
        .clk_i (clk), .rst_i (rst),
        .rd_addr_i (rd_addr), .rd_valid_i (rd_valid),
        .rd_data_o (rd_data_b0), .rd_valid_o (rd_valid_b0),
        .wr_addr_i (wr_addr), .wr_data_i (wr_data), .wr_valid_i (wr_valid),
        .init_done_o (init_b0), .wr_conflict_o (conf_b0)
    );

    typedef struct {
        logic [1:0] wv;
        logic [3:0] wa0;
        logic [7:0] wd0;
        logic [3:0] wa1;
        logic [7:0] wd1;
        logic [1:0] rv;
        logic [3:0] ra0;
        logic [3:0] ra1;
        logic [1:0] ev;
        logic       ec;
        logic [7:0] b1_0;
        logic [7:0] b1_1;
        logic [7:0] b0_0;
        logic [7:0] b0_1;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wv, input logic [3:0] wa0, input logic [7:0] wd0,
                         input logic [3:0] wa1, input logic [7:0] wd1,
                         input logic [1:0] rv, input logic [3:0] ra0, input logic [3:0] ra1);
        wr_valid = wv;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rd_valid = rv;
        rd_addr  = {ra1, ra0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_init_b1"},  32'(init_b1),     32'h0);
        chk({tag, "_rdv_b1"},   32'(rd_valid_b1), 32'h0);
        chk({tag, "_rdd_b1"},   32'(rd_data_b1),  32'h0);
        chk({tag, "_conf_b1"},  32'(conf_b1),     32'h0);
        chk({tag, "_init_b0"},  32'(init_b0),     32'h0);
        chk({tag, "_rdv_b0"},   32'(rd_valid_b0), 32'h0);
        chk({tag, "_rdd_b0"},   32'(rd_data_b0),  32'h0);
    endtask

    initial begin
        //               wv     wa0   wd0    wa1   wd1    rv     ra0    ra1    ev     ec    b1_0   b1_1   b0_0   b0_1
        tbl[0]  = '{2'b11, 4'd3, 8'h11, 4'd7, 8'h22, 2'b00, 4'd0,  4'd0,  2'b00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        tbl[1]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd3,  4'd7,  2'b11, 1'b0, 8'h11, 8'h22, 8'h11, 8'h22};
        tbl[2]  = '{2'b11, 4'd5, 8'h33, 4'd5, 8'h44, 2'b00, 4'd0,  4'd0,  2'b00, 1'b1, 8'h11, 8'h22, 8'h11, 8'h22};
        tbl[3]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd5,  4'd5,  2'b11, 1'b0, 8'h44, 8'h44, 8'h44, 8'h44};
        tbl[4]  = '{2'b01, 4'd9, 8'h55, 4'd0, 8'h00, 2'b11, 4'd9,  4'd9,  2'b11, 1'b0, 8'h55, 8'h55, 8'hA5, 8'hA5};
        tbl[5]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b10, 4'd0,  4'd9,  2'b10, 1'b0, 8'h55, 8'h55, 8'hA5, 8'h55};
        tbl[6]  = '{2'b01, 4'd4, 8'h77, 4'd0, 8'h00, 2'b11, 4'd4,  4'd4,  2'b11, 1'b0, 8'h77, 8'h77, 8'hA5, 8'hA5};
        tbl[7]  = '{2'b11, 4'd10, 8'h01, 4'd11, 8'h02, 2'b11, 4'd10, 4'd11, 2'b11, 1'b0, 8'h01, 8'h02, 8'hA5, 8'hA5};
        tbl[8]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd10, 4'd11, 2'b11, 1'b0, 8'h01, 8'h02, 8'h01, 8'h02};
        tbl[9]  = '{2'b11, 4'd12, 8'h88, 4'd12, 8'h99, 2'b11, 4'd12, 4'd12, 2'b11, 1'b1, 8'h99, 8'h99, 8'hA5, 8'hA5};
        tbl[10] = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd12, 4'd4,  2'b11, 1'b0, 8'h99, 8'h77, 8'h99, 8'h77};

        rst = 1'b1;
        drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0);
        step();
        step();
        chk_reset_outputs("por");

        // Init sweep with reads requested every cycle
        rst = 1'b0;
        drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd0, 4'd1);
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("sweep%0d_rdv", c),  32'(rd_valid_b1), 32'h0);
            chk($sformatf("sweep%0d_init", c), 32'(init_b1),     32'h0);
        end
        step();
        chk("sweep9_init_b1", 32'(init_b1),     32'h1);
        chk("sweep9_init_b0", 32'(init_b0),     32'h1);
        chk("sweep9_rdv",     32'(rd_valid_b1), 32'h3);
        chk("sweep9_rdd",     32'(rd_data_b1),  32'hA5A5);

        for (int a = 0; a < 16; a += 2) begin
            drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'(a), 4'(a + 1));
            step();
            chk($sformatf("initval_a%0d_b1", a), 32'(rd_data_b1), 32'hA5A5);
            chk($sformatf("initval_a%0d_b0", a), 32'(rd_data_b0), 32'hA5A5);
        end

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].wv, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
                  tbl[i].rv, tbl[i].ra0, tbl[i].ra1);
            step();
            chk($sformatf("t%0d_rdv_b1", i),  32'(rd_valid_b1), 32'(tbl[i].ev));
            chk($sformatf("t%0d_rdv_b0", i),  32'(rd_valid_b0), 32'(tbl[i].ev));
            chk($sformatf("t%0d_conf_b1", i), 32'(conf_b1),     32'(tbl[i].ec));
            chk($sformatf("t%0d_conf_b0", i), 32'(conf_b0),     32'(tbl[i].ec));
            chk($sformatf("t%0d_rdd_b1", i),  32'(rd_data_b1),  32'({tbl[i].b1_1, tbl[i].b1_0}));
            chk($sformatf("t%0d_rdd_b0", i),  32'(rd_data_b0),  32'({tbl[i].b0_1, tbl[i].b0_0}));
        end

        // Mid-run reset: pre-reset write, then conflicting writes held through the sweep
        drive(2'b01, 4'd2, 8'h66, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0);
        step();
        rst = 1'b1;
        drive(2'b11, 4'd2, 8'hEE, 4'd2, 8'hEF, 2'b11, 4'd2, 4'd2);
        step();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("midsweep%0d_rdv", c),  32'(rd_valid_b1), 32'h0);
            chk($sformatf("midsweep%0d_conf", c), 32'(conf_b1),     32'h0);
            chk($sformatf("midsweep%0d_init", c), 32'(init_b1),     32'h0);
        end
        drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd2, 4'd3);
        step();
        chk("midend_init", 32'(init_b1),     32'h1);
        chk("midend_rdv",  32'(rd_valid_b1), 32'h3);
        chk("midend_b1",   32'(rd_data_b1),  32'hA5A5);
        chk("midend_b0",   32'(rd_data_b0),  32'hA5A5);
        chk("midend_conf", 32'(conf_b1),     32'h0);

        drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
